// File: rtl/hex_page_scheduler.sv
// hex_page_scheduler
// Sequences the HEX display between up to four page sources. Pages rotate
// automatically after DWELL cycles or step manually on a debounced, active-low
// KEY press. Pages without a source are skipped. The display is blanked when no
// page is valid.
module hex_page_scheduler #(
  parameter int DWELL = 50_000_000,
  parameter int DEB   = 500_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       auto_en,
  input  logic       step_key,
  input  logic [3:0] page_valid,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       page_tick
);

  localparam int TW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int CW = (DEB > 2) ? $clog2(DEB) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(DWELL - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB - 1);

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  // Returns the first valid page after p in cyclic order p+1, p+2, p+3.
  // Returns p itself when no other page is valid.
  function automatic logic [1:0] next_page(input logic [1:0] p,
                                           input logic [3:0] v);
    logic [1:0] r;
    logic [1:0] c;
    r = p;
    for (int k = 3; k >= 1; k--) begin
      c = p + 2'(k);
      if (v[c]) r = c;
    end
    return r;
  endfunction

  logic          key_sync_p0;
  logic          key_sync_p1;
  logic          key_db;
  logic          key_db_d;
  logic [CW-1:0] deb_cnt;
  logic          press;

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic [1:0]    sel_n;
  logic          sel_valid_n;
  logic          page_tick_n;
  logic          advance;
  logic [1:0]    cand;

  // Two-flop synchroniser for the asynchronous pushbutton. It idles released (high).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_sync_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
    end else begin
      key_sync_p0 <= step_key;
      key_sync_p1 <= key_sync_p0;
    end
  end

  // Debounce: accept a new level only after DEB consecutive differing samples.
  // Any sample that matches the current level restarts the count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_db   <= 1'b1;
      key_db_d <= 1'b1;
      deb_cnt  <= '0;
    end else begin
      key_db_d <= key_db;
      if (key_sync_p1 != key_db) begin
        if (deb_cnt == DEB_LAST) begin
          key_db  <= key_sync_p1;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + CW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // A press is the debounced falling edge. The release edge is ignored.
  assign press = key_db_d & ~key_db;

  // Page sequencer state and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      sel       <= 2'd0;
      sel_valid <= 1'b0;
      page_tick <= 1'b0;
      timer     <= '0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      sel_valid <= sel_valid_n;
      page_tick <= page_tick_n;
      timer     <= timer_n;
    end
  end

  // Next-state logic. A press, dwell expiry and an invalid current page all
  // merge into one advance, so coincident causes step the page only once.
  always_comb begin
    state_n     = state;
    sel_n       = sel;
    sel_valid_n = sel_valid;
    page_tick_n = 1'b0;
    timer_n     = timer;
    advance     = 1'b0;
    cand        = next_page(sel, page_valid);
    case (state)
      IDLE: begin
        timer_n     = '0;
        sel_valid_n = 1'b0;
        if (page_valid != 4'b0000) begin
          state_n     = SHOW;
          sel_n       = next_page(2'd3, page_valid);
          sel_valid_n = 1'b1;
          page_tick_n = 1'b1;
        end
      end
      SHOW: begin
        if (page_valid == 4'b0000) begin
          state_n     = IDLE;
          sel_valid_n = 1'b0;
          timer_n     = '0;
        end else begin
          advance = press | (auto_en & (timer == TIMER_LAST)) | ~page_valid[sel];
          if (advance) begin
            sel_n       = cand;
            timer_n     = '0;
            page_tick_n = (cand != sel);
          end else if (auto_en) begin
            timer_n = timer + TW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hex_page_scheduler.sv
// Testbench for hex_page_scheduler: table-driven vectors, hand-written corner
// sequences and randomized stimulus against a behavioural reference model.
module tb_hex_page_scheduler;

  localparam int DWELL = 4;
  localparam int DEB   = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       auto_en = 1'b0;
  logic       step_key = 1'b1;
  logic [3:0] page_valid = 4'b0000;
  logic [1:0] sel;
  logic       sel_valid;
  logic       page_tick;

  hex_page_scheduler #(.DWELL(DWELL), .DEB(DEB)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .auto_en   (auto_en),
    .step_key  (step_key),
    .page_valid(page_valid),
    .sel       (sel),
    .sel_valid (sel_valid),
    .page_tick (page_tick)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int ticks = 0;

  // Reference model state
  bit         m_show;
  logic [1:0] m_sel;
  bit         m_valid;
  bit         m_tick;
  int         m_timer;
  bit         m_db;
  bit         m_press;
  bit         raw_q[$];
  bit         s2w[$];

  typedef struct {
    logic       ae;
    logic [3:0] pv;
    logic [1:0] s;
    logic       v;
    logic       t;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_next(input logic [1:0] p, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (int'(p) + k) % 4;
      if (v[c]) return 2'(c);
    end
    return p;
  endfunction

  function automatic logic [1:0] m_lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_show  = 1'b0;
    m_sel   = 2'd0;
    m_valid = 1'b0;
    m_tick  = 1'b0;
    m_timer = 0;
    m_db    = 1'b1;
    m_press = 1'b0;
    raw_q.delete();
    raw_q.push_back(1'b1);
    raw_q.push_back(1'b1);
    s2w.delete();
  endtask

  // One clock edge of behaviour, using the inputs present at that edge.
  task automatic model_step();
    bit         s2_old;
    bit         press_now;
    bit         all_diff;
    bit         adv;
    logic [1:0] nx;
    press_now = m_press;
    s2_old = raw_q[0];
    s2w.push_back(s2_old);
    if (s2w.size() > DEB) void'(s2w.pop_front());
    m_press = 1'b0;
    if (s2w.size() == DEB) begin
      all_diff = 1'b1;
      foreach (s2w[i]) if (s2w[i] == m_db) all_diff = 1'b0;
      if (all_diff) begin
        m_db = ~m_db;
        m_press = (m_db == 1'b0);
      end
    end
    void'(raw_q.pop_front());
    raw_q.push_back(step_key);

    m_tick = 1'b0;
    if (!m_show) begin
      m_timer = 0;
      if (page_valid != 4'b0000) begin
        m_show  = 1'b1;
        m_sel   = m_lowest(page_valid);
        m_valid = 1'b1;
        m_tick  = 1'b1;
      end
    end else if (page_valid == 4'b0000) begin
      m_show  = 1'b0;
      m_valid = 1'b0;
      m_timer = 0;
    end else begin
      adv = press_now || (auto_en && m_timer == DWELL - 1) || !page_valid[m_sel];
      if (adv) begin
        nx = m_next(m_sel, page_valid);
        m_tick = (nx != m_sel);
        m_sel = nx;
        m_timer = 0;
      end else if (auto_en) begin
        m_timer++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    if (!resetn) model_reset();
    else model_step();
    #1;
    check("model_sel", sel, m_sel);
    check("model_sel_valid", sel_valid, m_valid);
    check("model_page_tick", page_tick, m_tick);
    check("model_timer", dut.timer, m_timer);
    if (page_tick === 1'b1) ticks++;
  endtask

  task automatic do_reset();
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("reset_sel", sel, 0);
    check("reset_sel_valid", sel_valid, 0);
    check("reset_page_tick", page_tick, 0);
    check("reset_timer", dut.timer, 0);
    cycle();
    cycle();
    resetn = 1'b1;
  endtask

  task automatic add(input int n, input logic ae, input logic [3:0] pv,
                     input logic [1:0] s, input logic v, input logic t);
    vec_t r;
    r.ae = ae;
    r.pv = pv;
    r.s  = s;
    r.v  = v;
    r.t  = t;
    repeat (n) tbl.push_back(r);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int key_run;

    // Auto rotation over all pages, then alternating pages, removal, blanking.
    add(1, 1, 4'hF, 0, 1, 1); add(3, 1, 4'hF, 0, 1, 0);
    add(1, 1, 4'hF, 1, 1, 1); add(3, 1, 4'hF, 1, 1, 0);
    add(1, 1, 4'hF, 2, 1, 1); add(3, 1, 4'hF, 2, 1, 0);
    add(1, 1, 4'hF, 3, 1, 1); add(3, 1, 4'hF, 3, 1, 0);
    add(1, 1, 4'hF, 0, 1, 1);
    add(1, 1, 4'hA, 1, 1, 1); add(3, 1, 4'hA, 1, 1, 0);
    add(1, 1, 4'hA, 3, 1, 1); add(3, 1, 4'hA, 3, 1, 0);
    add(1, 1, 4'hA, 1, 1, 1); add(3, 1, 4'hA, 1, 1, 0);
    add(1, 1, 4'hA, 3, 1, 1);
    add(1, 1, 4'h2, 1, 1, 1);
    add(1, 1, 4'h0, 1, 0, 0); add(2, 1, 4'h0, 1, 0, 0);
    add(1, 1, 4'hA, 1, 1, 1);

    auto_en = 1'b1;
    page_valid = 4'hF;
    step_key = 1'b1;
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      auto_en = tbl[i].ae;
      page_valid = tbl[i].pv;
      cycle();
      check("tbl_sel", sel, tbl[i].s);
      check("tbl_sel_valid", sel_valid, tbl[i].v);
      check("tbl_page_tick", page_tick, tbl[i].t);
    end

    // Manual stepping: short glitch ignored, long press advances once.
    auto_en = 1'b0;
    page_valid = 4'hF;
    step_key = 1'b1;
    do_reset();
    cycle();
    step_key = 1'b0;
    cycle(); cycle();
    step_key = 1'b1;
    repeat (8) cycle();
    check("short_press_sel", sel, 0);
    ticks = 0;
    step_key = 1'b0;
    repeat (5) cycle();
    check("press_latency_before", sel, 0);
    cycle();
    check("press_latency_sel", sel, 1);
    check("press_latency_tick", page_tick, 1);
    repeat (2) cycle();
    step_key = 1'b1; cycle();
    step_key = 1'b0; cycle();
    step_key = 1'b1;
    repeat (10) cycle();
    check("one_advance_ticks", ticks, 1);
    check("after_release_sel", sel, 1);

    // Press coinciding with dwell expiry gives a single advance.
    auto_en = 1'b1;
    page_valid = 4'hF;
    step_key = 1'b1;
    do_reset();
    repeat (3) cycle();
    step_key = 1'b0;
    repeat (5) cycle();
    check("coincide_pre_sel", sel, 1);
    check("coincide_pre_timer", dut.timer, 3);
    cycle();
    check("coincide_sel", sel, 2);
    check("coincide_tick", page_tick, 1);
    check("coincide_timer", dut.timer, 0);
    step_key = 1'b1;
    repeat (3) cycle();
    check("coincide_hold_sel", sel, 2);
    cycle();
    check("coincide_next_sel", sel, 3);

    // Single valid page: no ticks after entry, timer keeps wrapping.
    auto_en = 1'b1;
    page_valid = 4'h4;
    step_key = 1'b1;
    do_reset();
    cycle();
    check("single_entry_sel", sel, 2);
    check("single_entry_tick", page_tick, 1);
    ticks = 0;
    repeat (3) cycle();
    check("single_timer_max", dut.timer, 3);
    cycle();
    check("single_timer_wrap", dut.timer, 0);
    step_key = 1'b0;
    repeat (8) cycle();
    step_key = 1'b1;
    repeat (8) cycle();
    check("single_no_ticks", ticks, 0);
    check("single_sel", sel, 2);

    // Asynchronous reset mid-dwell, then restart on a different page set.
    auto_en = 1'b1;
    page_valid = 4'hF;
    step_key = 1'b1;
    do_reset();
    repeat (14) cycle();
    check("async_pre_sel", sel, 3);
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    check("async_sel", sel, 0);
    check("async_sel_valid", sel_valid, 0);
    check("async_timer", dut.timer, 0);
    page_valid = 4'hA;
    cycle();
    resetn = 1'b1;
    cycle();
    check("async_restart_sel", sel, 1);
    check("async_restart_valid", sel_valid, 1);
    check("async_restart_tick", page_tick, 1);

    // Randomized stimulus against the reference model.
    auto_en = 1'b1;
    page_valid = 4'hF;
    step_key = 1'b1;
    do_reset();
    key_run = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 31) == 0) page_valid = 4'($urandom_range(0, 15));
      if (key_run == 0) begin
        step_key = 1'($urandom_range(0, 1));
        key_run = $urandom_range(1, 10);
      end
      key_run--;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
